// File: rtl/lc_mem_arbiter_pkg.sv
// Shared definitions for the layer-controller memory arbiter: state encoding,
// default memory widths and the default acknowledge timeout.
package lc_mem_arbiter_pkg;

  localparam int unsigned LcMemAddrWidth    = 30;
  localparam int unsigned LcMemDataWidth    = 32;
  localparam int unsigned LcMemTimeout      = 255;
  localparam int unsigned LcMemTimeoutWidth = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

endpackage

// File: rtl/lc_mem_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the port that was not granted last.
module lc_mem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/lc_mem_arbiter.sv
// Shares one layer-controller memory port between the MBus layer controller
// (port 0) and a local master (port 1) using 4-phase REQ/ACK handshakes.
module lc_mem_arbiter
  import lc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = LcMemAddrWidth,
  parameter int unsigned DATA_W  = LcMemDataWidth,
  parameter int unsigned TIMEOUT = LcMemTimeout,
  parameter int unsigned TO_W    = LcMemTimeoutWidth
) (
  input  logic              CLK,
  input  logic              MEM_ACK_RSTn,
  input  logic              P0_REQ,
  input  logic              P0_WRITE,
  input  logic [ADDR_W-1:0] P0_ADDR,
  input  logic [DATA_W-1:0] P0_WDATA,
  output logic              P0_ACK,
  output logic              P0_ERR,
  input  logic              P1_REQ,
  input  logic              P1_WRITE,
  input  logic [ADDR_W-1:0] P1_ADDR,
  input  logic [DATA_W-1:0] P1_WDATA,
  output logic              P1_ACK,
  output logic              P1_ERR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              MEM_REQ_OUT,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_AOUT,
  output logic [DATA_W-1:0] MEM_DOUT,
  input  logic              MEM_ACK_IN,
  input  logic [DATA_W-1:0] MEM_DIN,
  output logic              GRANT,
  output logic              BUSY
);

  localparam bit              TimeoutEn   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TimeoutLast = TO_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_aout_q, mem_aout_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;

  logic [1:0] req;
  logic       pick_valid;
  logic       pick_winner;

  assign req = {P1_REQ, P0_REQ};

  lc_mem_rr_pick u_pick (
    .req    (req),
    .last   (last_grant_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_write_d  = mem_write_q;
    mem_aout_d   = mem_aout_q;
    mem_dout_d   = mem_dout_q;
    rd_data_d    = rd_data_q;
    ack_d        = ack_q;
    err_d        = err_q;
    grant_d      = grant_q;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d     = pick_winner;
          mem_write_d = pick_winner ? P1_WRITE : P0_WRITE;
          mem_aout_d  = pick_winner ? P1_ADDR : P0_ADDR;
          mem_dout_d  = pick_winner ? P1_WDATA : P0_WDATA;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (MEM_ACK_IN) begin
          mem_req_d = 1'b0;
          if (!mem_write_q) begin
            rd_data_d = MEM_DIN;
          end
          ack_d[grant_q] = 1'b1;
          state_d        = StRelease;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          mem_req_d      = 1'b0;
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          state_d        = StRelease;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StRelease: begin
        // A late memory acknowledge after a timeout must also drain here.
        if (!req[grant_q] && !MEM_ACK_IN) begin
          ack_d        = '0;
          err_d        = '0;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge MEM_ACK_RSTn) begin
    if (!MEM_ACK_RSTn) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_aout_q   <= '0;
      mem_dout_q   <= '0;
      rd_data_q    <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_aout_q   <= mem_aout_d;
      mem_dout_q   <= mem_dout_d;
      rd_data_q    <= rd_data_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  assign P0_ACK      = ack_q[0];
  assign P1_ACK      = ack_q[1];
  assign P0_ERR      = err_q[0];
  assign P1_ERR      = err_q[1];
  assign RD_DATA     = rd_data_q;
  assign MEM_REQ_OUT = mem_req_q;
  assign MEM_WRITE   = mem_write_q;
  assign MEM_AOUT    = mem_aout_q;
  assign MEM_DOUT    = mem_dout_q;
  assign GRANT       = grant_q;
  assign BUSY        = busy_q;

endmodule

// File: doc/lc_mem_arbiter.md
# lc_mem_arbiter

Two-port arbiter sharing one layer-controller memory port between the MBus layer controller (port 0) and a local master such as a sensor DMA or CPU (port 1). Each port uses the same 4-phase REQ/ACK memory handshake. The arbiter selects a winner by round-robin, registers that winner's command onto the memory port, returns the read data and acknowledge to it, and aborts with an error if the memory does not respond within a bounded time. It sits between the layer controller's MEM_* pins and the layer SRAM wrapper.

## Interface
- ADDR_W, default 30: word address width (`LC_MEM_ADDR_WIDTH-2).
- DATA_W, default 32: data width (`LC_MEM_DATA_WIDTH).
- TIMEOUT, default 255: maximum number of ISSUE cycles without MEM_ACK_IN before the transaction aborts; 0 disables the timeout.
- TO_W, default 8: width of the timeout counter; must hold TIMEOUT.

Reset and clock: reset MEM_ACK_RSTn, asynchronous, active-low; clock CLK.

- CLK  in  1  clock
- MEM_ACK_RSTn  in  1  async active-low reset
- P0_REQ, P1_REQ  in  1  request, held until Pn_ACK rises
- P0_WRITE, P1_WRITE  in  1  1 = write, 0 = read; stable while REQ high
- P0_ADDR, P1_ADDR  in  ADDR_W  word address
- P0_WDATA, P1_WDATA  in  DATA_W  write data
- P0_ACK, P1_ACK  out  1  transaction done, held until Pn_REQ falls
- P0_ERR, P1_ERR  out  1  timeout abort; valid while Pn_ACK is high
- RD_DATA  out  DATA_W  read data; valid while the granted Pn_ACK is high
- MEM_REQ_OUT  out  1  memory request
- MEM_WRITE  out  1  memory write enable
- MEM_AOUT  out  ADDR_W  memory address
- MEM_DOUT  out  DATA_W  memory write data
- MEM_ACK_IN  in  1  memory acknowledge (4-phase)
- MEM_DIN  in  DATA_W  memory read data
- GRANT  out  1  index of the port currently or last granted
- BUSY  out  1  high whenever the state is not IDLE

## Operation
- All outputs are registered.
- Reset values: every output is 0; state = IDLE; last_grant = 1, so port 0 wins the first tie; timeout counter = 0.
- State IDLE:
  - If any REQ is high, pick a winner. One requester wins outright. If both request, the port ≠ last_grant wins.
  - Latch the winner's ADDR, WDATA and WRITE into MEM_AOUT, MEM_DOUT and MEM_WRITE.
  - Set MEM_REQ_OUT = 1 and GRANT = winner. Clear the counter. Go to ISSUE.
- State ISSUE:
  - If MEM_ACK_IN is high: set MEM_REQ_OUT = 0. For a read, load MEM_DIN into RD_DATA; for a write, RD_DATA holds its value. Set Pg_ACK = 1. Go to RELEASE.
  - Else, if TIMEOUT ≠ 0 and counter == TIMEOUT-1: set MEM_REQ_OUT = 0, Pg_ACK = 1, Pg_ERR = 1. Go to RELEASE.
  - Otherwise increment the counter.
- State RELEASE:
  - Wait until Pg_REQ == 0 and MEM_ACK_IN == 0, both sampled in the same cycle.
  - Then clear Pg_ACK and Pg_ERR, set last_grant = g, and go to IDLE.
- The non-granted port's ACK and ERR stay 0 for the whole transaction.
- MEM_AOUT, MEM_DOUT and MEM_WRITE hold their values from grant until the next grant.
- A requester dropping REQ during ISSUE is a protocol violation. The transaction still completes and RELEASE exits on the first legal cycle.
- A port that requests during another port's transaction is served on a later IDLE pass. The request is not lost.
- A late MEM_ACK_IN arriving after a timeout keeps the arbiter in RELEASE until MEM_ACK_IN falls. No new request is issued to memory meanwhile.

## Timing
- REQ high at edge N in IDLE gives MEM_REQ_OUT high after edge N.
- MEM_ACK_IN high at edge M in ISSUE gives Pg_ACK high and RD_DATA valid after edge M.
- Minimum transaction is 3 cycles (IDLE, ISSUE, RELEASE). IDLE is always visited between transactions, so there is no back-to-back issue.
- With both ports continuously requesting, grants alternate 0, 1, 0, 1.
- The timeout fires on the TIMEOUT-th ISSUE cycle without an acknowledge.
- Asserting reset mid-transaction drops MEM_REQ_OUT and all ACK/ERR outputs immediately (asynchronous). The memory must tolerate an abandoned request.

## Structure
- Shared include (mbus_def.v) holds the state encoding (IDLE = 2'd0, ISSUE = 2'd1, RELEASE = 2'd2), the LC_MEM width macros, and the default TIMEOUT.
- Sub-module lc_mem_rr_pick: combinational 2-way round-robin picker with inputs req[1:0] and last, outputs valid and winner. The main module holds the FSM, the timeout counter and the datapath registers.

## Test plan
- Reset release, then P0 reads 0x10 and memory returns 0xDEADBEEF after 2 cycles → MEM_REQ_OUT rises 1 cycle after REQ; P0_ACK = 1; RD_DATA = 0xDEADBEEF; P0_ERR = 0.
- P1 writes 0xCAFE0001 to 0x3F → MEM_WRITE = 1, MEM_AOUT = 0x3F, MEM_DOUT = 0xCAFE0001; P0_ACK stays 0.
- P0 and P1 request in the same cycle, held for 4 transactions → grant order 0, 1, 0, 1; GRANT toggles each time.
- Memory never acknowledges, TIMEOUT = 8 → MEM_REQ_OUT falls after 8 ISSUE cycles; P0_ACK = 1 and P0_ERR = 1; both clear when P0_REQ falls.
- Timeout followed by a late MEM_ACK_IN pulse → BUSY stays high until MEM_ACK_IN falls; the next request issues only after that.
- Reset asserted in ISSUE → MEM_REQ_OUT, ACK and BUSY go to 0 asynchronously; after release, P0 wins the first tie.
